// File: rtl/nibble_initiator_pkg.sv
// Shared definitions for the nibble port initiator.
//   nibble_initiator_state_t : FSM state encoding (IDLE, SEND, RESP)
//   NIBBLE_ADDR_WIDTH        : width of the beat address bus A
//   NIBBLE_DATA_WIDTH        : width of one beat data nibble y
package nibble_initiator_pkg;

    localparam int NIBBLE_ADDR_WIDTH = 8;
    localparam int NIBBLE_DATA_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RESP = 2'd2
    } nibble_initiator_state_t;

endpackage

// File: rtl/nibble_initiator_ack_timer.sv
// Wait counter for one beat's acknowledge.
//   clk, rst_n : clock, async active-low reset
//   i_clear    : zero the counter (takes priority over i_enable)
//   i_enable   : count one wait cycle
//   o_expired  : this wait cycle is the TIMEOUT-th consecutive one
module ack_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Combinational so the FSM can abort on the same edge the count would
    // reach TIMEOUT; the caller only enables while no ack is present.
    assign o_expired = i_enable && (r_count == LAST_WAIT);

endmodule

// File: rtl/nibble_initiator.sv
// Write initiator for module N's nibble port. A request accepted on
// req_valid/req_ready is sent as NIBBLES beats on A/x/y, LS nibble first,
// each beat held until z acknowledges it or the ack timer expires.
//   clk, rst_n          : clock, async active-low reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_addr, req_data  : base address and write data
//   rsp_valid, rsp_err  : one-cycle completion strobe, err=1 on timeout
//   A, x, y             : beat address, beat valid, beat nibble
//   z                   : responder acknowledge
//
// state | meaning
// IDLE  | ready for a request, no beat driven
// SEND  | beat idx driven, waiting for z
// RESP  | response strobe cycle
module nibble_initiator
    import nibble_initiator_pkg::*;
#(
    parameter int NIBBLES = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [NIBBLE_ADDR_WIDTH-1:0]  req_addr,
    input  logic [4*NIBBLES-1:0]          req_data,
    output logic                          rsp_valid,
    output logic                          rsp_err,
    output logic [NIBBLE_ADDR_WIDTH-1:0]  A,
    output logic                          x,
    output logic [NIBBLE_DATA_WIDTH-1:0]  y,
    input  logic                          z
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    nibble_initiator_state_t r_state, w_state_nxt;

    logic [NIBBLE_ADDR_WIDTH-1:0]              r_addr, w_addr_nxt;
    logic [NIBBLES-1:0][NIBBLE_DATA_WIDTH-1:0] r_data, w_data_nxt;
    logic [IDX_W-1:0]                          r_idx, w_idx_nxt, w_idx_inc;

    logic [NIBBLE_ADDR_WIDTH-1:0] r_beat_addr, w_beat_addr_nxt;
    logic                         r_beat_valid, w_beat_valid_nxt;
    logic [NIBBLE_DATA_WIDTH-1:0] r_beat_data, w_beat_data_nxt;
    logic                         r_rsp_valid, w_rsp_valid_nxt;
    logic                         r_rsp_err, w_rsp_err_nxt;

    logic w_timer_clear;
    logic w_timer_en;
    logic w_expired;

    // z only matters while a beat is on the bus (x=1 exactly in SEND).
    assign w_timer_en    = (r_state == SEND) && !z;
    assign w_timer_clear = (r_state != SEND) || z;

    ack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_ack_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_timer_clear),
        .i_enable  (w_timer_en),
        .o_expired (w_expired)
    );

    assign w_idx_inc = r_idx + 1'b1;

    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_data_nxt       = r_data;
        w_idx_nxt        = r_idx;
        w_beat_addr_nxt  = r_beat_addr;
        w_beat_valid_nxt = r_beat_valid;
        w_beat_data_nxt  = r_beat_data;
        w_rsp_valid_nxt  = 1'b0;
        w_rsp_err_nxt    = r_rsp_err;

        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    // First beat is loaded straight from the request so it
                    // appears in the cycle right after acceptance.
                    w_state_nxt      = SEND;
                    w_addr_nxt       = req_addr;
                    w_data_nxt       = req_data;
                    w_idx_nxt        = '0;
                    w_beat_addr_nxt  = req_addr;
                    w_beat_valid_nxt = 1'b1;
                    w_beat_data_nxt  = req_data[NIBBLE_DATA_WIDTH-1:0];
                end
            end
            SEND: begin
                // Ack is checked first so a z arriving on the last
                // allowed wait cycle still completes the beat.
                if (z) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt      = RESP;
                        w_beat_valid_nxt = 1'b0;
                        w_rsp_valid_nxt  = 1'b1;
                        w_rsp_err_nxt    = 1'b0;
                    end else begin
                        w_idx_nxt       = w_idx_inc;
                        w_beat_addr_nxt = r_addr + NIBBLE_ADDR_WIDTH'(w_idx_inc);
                        w_beat_data_nxt = r_data[w_idx_inc];
                    end
                end else if (w_expired) begin
                    w_state_nxt      = RESP;
                    w_beat_valid_nxt = 1'b0;
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_err_nxt    = 1'b1;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt      = IDLE;
                w_beat_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_data       <= '0;
            r_idx        <= '0;
            r_beat_addr  <= '0;
            r_beat_valid <= 1'b0;
            r_beat_data  <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_data       <= w_data_nxt;
            r_idx        <= w_idx_nxt;
            r_beat_addr  <= w_beat_addr_nxt;
            r_beat_valid <= w_beat_valid_nxt;
            r_beat_data  <= w_beat_data_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_err    <= w_rsp_err_nxt;
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign A         = r_beat_addr;
    assign x         = r_beat_valid;
    assign y         = r_beat_data;

endmodule

// File: tb/tb_nibble_initiator.sv
// Self-checking bench for nibble_initiator: a NIBBLES=2 instance driven from
// a vector table plus hand sequences, and a NIBBLES=4 instance for address wrap.
module tb_nibble_initiator;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst_n;

    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_addr;
    logic [7:0]  req_data;
    logic        rsp_valid;
    logic        rsp_err;
    logic [7:0]  A;
    logic        x;
    logic [3:0]  y;
    logic        z;

    logic        req4_valid;
    logic        req4_ready;
    logic [7:0]  req4_addr;
    logic [15:0] req4_data;
    logic        rsp4_valid;
    logic        rsp4_err;
    logic [7:0]  A4;
    logic        x4;
    logic [3:0]  y4;
    logic        z4;

    nibble_initiator #(.NIBBLES(2), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .A         (A),
        .x         (x),
        .y         (y),
        .z         (z)
    );

    nibble_initiator #(.NIBBLES(4), .TIMEOUT(TIMEOUT)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req4_valid),
        .req_ready (req4_ready),
        .req_addr  (req4_addr),
        .req_data  (req4_data),
        .rsp_valid (rsp4_valid),
        .rsp_err   (rsp4_err),
        .A         (A4),
        .x         (x4),
        .y         (y4),
        .z         (z4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [11:0] beat_q[$];
    logic        rsp_q[$];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         w0;       // wait cycles before ack on beat 0 (>=TIMEOUT: never)
        int         w1;       // same for beat 1
        logic       exp_err;
        int         exp_lat;  // cycle of rsp_valid counted from acceptance
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic pop_beat(input string nm, input logic [11:0] act);
        if (beat_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s actual=%0h required=none", nm, act);
        end else begin
            chk(nm, {20'd0, act}, {20'd0, beat_q.pop_front()});
        end
    endtask

    task automatic pop_rsp(input string nm, input logic act);
        if (rsp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s actual=%0b required=none", nm, act);
        end else begin
            chk(nm, {31'd0, act}, {31'd0, rsp_q.pop_front()});
        end
    endtask

    task automatic run_vec(input vec_t v);
        int  waits[2];
        int  b;
        int  w;
        int  cyc;
        int  xcnt;
        bit  done;
        waits[0] = v.w0;
        waits[1] = v.w1;
        for (int i = 0; i < 2; i++) begin
            if (waits[i] >= TIMEOUT) break;
            beat_q.push_back({8'(v.addr + 8'(i)), v.data[4*i +: 4]});
        end
        rsp_q.push_back(v.exp_err);

        @(negedge clk);
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_data  = v.data;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_data  = 8'($urandom);
        cyc  = 1;
        b    = 0;
        w    = 0;
        xcnt = 0;
        done = 1'b0;
        while (!done && cyc <= 40) begin
            if (rsp_valid) begin
                chk("rsp_latency", cyc, v.exp_lat);
                pop_rsp("rsp_err", rsp_err);
                chk("x_in_resp", {31'd0, x}, 32'd0);
                chk("ready_in_resp", {31'd0, req_ready}, 32'd0);
                chk("x_high_cycles", xcnt, v.exp_lat - 1);
                done = 1'b1;
            end else begin
                if (x) xcnt++;
                if (b < 2 && w < waits[b]) begin
                    z = 1'b0;
                    w++;
                end else begin
                    z = 1'b1;
                end
                if (x && z) begin
                    pop_beat("beat_A_y", {A, y});
                    b++;
                    w = 0;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        if (!done) chk("rsp_timeout", 32'd0, 32'd1);
        z = 1'b0;
        chk("beats_left", beat_q.size(), 32'd0);
        @(posedge clk);
        #1;
        chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
        chk("ready_after", {31'd0, req_ready}, 32'd1);
        chk("err_held", {31'd0, rsp_err}, {31'd0, v.exp_err});
        beat_q.delete();
        rsp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int ready_cyc;
        int nrsp;
        int rsp_cyc[$];

        vecs[0] = '{8'h10, 8'hA5, 0,  0,  1'b0, 3};
        vecs[1] = '{8'h20, 8'h3C, 3,  0,  1'b0, 6};
        vecs[2] = '{8'h30, 8'h5A, 99, 0,  1'b1, 16};
        vecs[3] = '{8'h40, 8'hF0, 14, 0,  1'b0, 17};
        vecs[4] = '{8'hFF, 8'h12, 0,  2,  1'b0, 5};
        vecs[5] = '{8'h50, 8'h77, 1,  99, 1'b1, 18};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 8'h00;
        req_data   = 8'h00;
        z          = 1'b0;
        req4_valid = 1'b0;
        req4_addr  = 8'h00;
        req4_data  = 16'h0000;
        z4         = 1'b1;

        #12;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_x", {31'd0, x}, 32'd0);
        chk("rst_A", {24'd0, A}, 32'd0);
        chk("rst_y", {28'd0, y}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_x4", {31'd0, x4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Back-to-back: second request held from the start, z high throughout
        // including the cycles with x=0.
        ready_cyc = -1;
        @(negedge clk);
        z         = 1'b1;
        req_valid = 1'b1;
        req_addr  = 8'h60;
        req_data  = 8'hB4;
        beat_q.push_back({8'h60, 4'h4});
        beat_q.push_back({8'h61, 4'hB});
        beat_q.push_back({8'h70, 4'h9});
        beat_q.push_back({8'h71, 4'hC});
        rsp_q.push_back(1'b0);
        rsp_q.push_back(1'b0);
        @(posedge clk);
        #1;
        req_addr = 8'h70;
        req_data = 8'hC9;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            if (rsp_valid) begin
                rsp_cyc.push_back(cyc);
                pop_rsp("b2b_rsp_err", rsp_err);
            end
            if (x && z) pop_beat("b2b_beat", {A, y});
            if (req_ready && ready_cyc < 0) ready_cyc = cyc;
            @(posedge clk);
            #1;
            if (ready_cyc >= 0) req_valid = 1'b0;
        end
        z = 1'b0;
        chk("b2b_ready_cycle", ready_cyc, 32'd4);
        chk("b2b_rsp_count", rsp_cyc.size(), 32'd2);
        if (rsp_cyc.size() == 2) begin
            chk("b2b_rsp1_cycle", rsp_cyc[0], 32'd3);
            chk("b2b_rsp2_cycle", rsp_cyc[1], 32'd7);
        end
        chk("b2b_beats_left", beat_q.size(), 32'd0);
        beat_q.delete();
        rsp_q.delete();

        // Address wrap on the 4-nibble instance, zero-wait responder.
        @(negedge clk);
        req4_valid = 1'b1;
        req4_addr  = 8'hFE;
        req4_data  = 16'h4321;
        beat_q.push_back({8'hFE, 4'h1});
        beat_q.push_back({8'hFF, 4'h2});
        beat_q.push_back({8'h00, 4'h3});
        beat_q.push_back({8'h01, 4'h4});
        @(posedge clk);
        #1;
        req4_valid = 1'b0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            chk("wrap_x", {31'd0, x4}, 32'd1);
            pop_beat("wrap_beat", {A4, y4});
            @(posedge clk);
            #1;
        end
        chk("wrap_rsp_valid", {31'd0, rsp4_valid}, 32'd1);
        chk("wrap_rsp_err", {31'd0, rsp4_err}, 32'd0);
        beat_q.delete();

        // Reset in the middle of a stalled beat.
        @(negedge clk);
        z         = 1'b0;
        req_valid = 1'b1;
        req_addr  = 8'h80;
        req_data  = 8'h3C;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("midrst_x_before", {31'd0, x}, 32'd1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_x_async", {31'd0, x}, 32'd0);
        chk("midrst_A_async", {24'd0, A}, 32'd0);
        chk("midrst_y_async", {28'd0, y}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nrsp = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) nrsp++;
        end
        chk("midrst_no_rsp", nrsp, 32'd0);
        chk("midrst_x_idle", {31'd0, x}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
